fir_mac_seq: RTL

FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

---
 rtl/fir_pkg.sv | 20 ++
 rtl/tap_round_sat.sv | 48 ++++
 rtl/fir_mac_seq.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared FSM encoding and derived-size helpers for the sequential FIR MAC.
package fir_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } fir_state_e;

    // Accumulator wide enough that ORD full-scale taps can never overflow it.
    function automatic int acc_width(input int width, input int ord);
        return width + $clog2(ord);
    endfunction

    // Number of RUN cycles needed to cover all taps.
    function automatic int beat_count(input int ord, input int lanes);
        return ord / lanes;
    endfunction

endpackage

// File: rtl/tap_round_sat.sv
// One MAC lane: full-precision product, round half-up, shift, then saturate or wrap.
module tap_round_sat #(
    parameter int WIDTH   = 16,
    parameter int S_NORM  = 12,
    parameter int S_FIRST = 12,
    parameter int SAT_EN  = 1
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] w,
    input  logic                    first,
    output logic signed [WIDTH-1:0] y,
    output logic                    ovf
);

    // One spare bit so the rounding bias can never overflow the product.
    localparam int PW = 2 * WIDTH + 1;

    function automatic logic signed [PW-1:0] half_lsb(input int s);
        logic signed [PW-1:0] r;
        r = '0;
        if (s > 0) r[s-1] = 1'b1;
        return r;
    endfunction

    localparam logic signed [PW-1:0] RndNorm  = half_lsb(S_NORM);
    localparam logic signed [PW-1:0] RndFirst = half_lsb(S_FIRST);
    localparam logic signed [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod;
    logic signed [PW-1:0]      prod_ext;
    logic signed [PW-1:0]      rounded;
    logic                      fits;

    // Round, shift and reduce one tap; tap 0 may use a smaller shift.
    always_comb begin
        prod     = x * w;
        prod_ext = $signed({prod[2*WIDTH-1], prod});
        if (first) rounded = (prod_ext + RndFirst) >>> S_FIRST;
        else       rounded = (prod_ext + RndNorm) >>> S_NORM;
        // Value fits iff every bit above the target sign bit matches it.
        fits = (&rounded[PW-1:WIDTH-1]) || !(|rounded[PW-1:WIDTH-1]);
        ovf  = !fits;
        if (fits || (SAT_EN == 0)) y = rounded[WIDTH-1:0];
        else                       y = rounded[PW-1] ? MinVal : MaxVal;
    end

endmodule

// File: rtl/fir_mac_seq.sv
// Sequential FIR dot product: LANES taps per cycle, registered result with valid/ready.
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int QP         = 12,
    parameter int ORD        = 64,
    parameter int LANES      = 4,
    parameter int SHIFT      = 0,
    parameter int FIRST_COND = 0,
    parameter int SAT_EN     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ORD*WIDTH-1:0]    filter_in_packed,
    input  logic [ORD*WIDTH-1:0]    weight_in_packed,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        y_out,
    output logic                    ovf
);

    localparam int AW    = acc_width(WIDTH, ORD);
    localparam int BEATS = beat_count(ORD, LANES);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    if (ORD % LANES != 0) begin : g_bad_lanes
        $error("fir_mac_seq: ORD must be a multiple of LANES");
    end

    fir_state_e               state_q, state_d;
    logic [BW-1:0]            beat_q;
    logic [ORD*WIDTH-1:0]     x_q, w_q;
    logic signed [AW-1:0]     acc_q;
    logic                     ovf_acc_q;
    logic signed [WIDTH-1:0]  y_q;
    logic                     ovf_q;

    logic signed [WIDTH-1:0]  lane_x [LANES];
    logic signed [WIDTH-1:0]  lane_w [LANES];
    logic signed [WIDTH-1:0]  lane_y [LANES];
    logic [LANES-1:0]         lane_ovf;

    logic                     last_beat;
    logic signed [AW-1:0]     acc_next;
    logic signed [WIDTH-1:0]  final_y;
    logic                     final_ovf;

    assign last_beat = (beat_q == BW'(BEATS - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_x[i] = x_q[WIDTH*(int'(beat_q)*LANES + i) +: WIDTH];
        assign lane_w[i] = w_q[WIDTH*(int'(beat_q)*LANES + i) +: WIDTH];

        tap_round_sat #(
            .WIDTH   (WIDTH),
            .S_NORM  (QP + SHIFT),
            .S_FIRST (QP + SHIFT - FIRST_COND),
            .SAT_EN  (SAT_EN)
        ) u_tap (
            .x     (lane_x[i]),
            .w     (lane_w[i]),
            .first ((i == 0) && (beat_q == '0)),
            .y     (lane_y[i]),
            .ovf   (lane_ovf[i])
        );
    end

    // Add this beat's reduced taps into the accumulator and reduce the total.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < LANES; i++) begin
            acc_next = acc_next + AW'(lane_y[i]);
        end
        final_ovf = !((&acc_next[AW-1:WIDTH-1]) || !(|acc_next[AW-1:WIDTH-1]));
        if (!final_ovf || (SAT_EN == 0)) final_y = acc_next[WIDTH-1:0];
        else                             final_y = acc_next[AW-1] ? MinVal : MaxVal;
    end

    // Next-state logic for the accept / run / hold-result sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid)  state_d = StRun;
            StRun:   if (last_beat) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register and datapath; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            x_q       <= '0;
            w_q       <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            y_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q       <= filter_in_packed;
                        w_q       <= weight_in_packed;
                        acc_q     <= '0;
                        ovf_acc_q <= 1'b0;
                        beat_q    <= '0;
                    end
                end
                StRun: begin
                    acc_q     <= acc_next;
                    ovf_acc_q <= ovf_acc_q | (|lane_ovf);
                    if (last_beat) begin
                        beat_q <= '0;
                        y_q    <= final_y;
                        ovf_q  <= ovf_acc_q | (|lane_ovf) | final_ovf;
                    end else begin
                        beat_q <= beat_q + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign y_out     = y_q;
    assign ovf       = ovf_q;

endmodule
